seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000, giving clk cycles per digit slot (minimum 2).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 The block SHALL have port load, input, 1, a single-cycle request to capture value_in.
REQ-005 The block SHALL have port value_in, input, 16, four BCD digits: [3:0] is digit 0 (rightmost) and [15:12] is digit 3.
REQ-006 The block SHALL have port blank_lz, input, 1, which enables leading-zero blanking.
REQ-007 The block SHALL have port bcd_out, output, 4, the active digit nibble driven to the shared bcd decoder.
REQ-008 The block SHALL have port an, output, 4, active-low digit enables, one bit per digit.
REQ-009 The block SHALL have port digit_idx, output, 2, the index of the active digit.
REQ-010 The block SHALL have port frame_done, output, 1, a one-cycle pulse at each frame boundary.
REQ-011 The block SHALL have port bad_bcd, output, 1, a sticky flag meaning the last load was rejected.

Function
REQ-012 The block SHALL implement two states: IDLE (display off, no value yet) and SCAN (multiplexing).
REQ-013 The slot counter SHALL count 0..REFRESH_DIV-1 in SCAN and assert tick when it reaches REFRESH_DIV-1, then wrap to 0.
REQ-014 On each tick, digit_idx SHALL advance 0->1->2->3->0.
REQ-015 A frame boundary SHALL be the tick where digit_idx wraps 3->0; frame_done SHALL be 1 for exactly that cycle.
REQ-016 In SCAN, an SHALL equal the bitwise inverse of (1 << digit_idx), unless the active digit is blanked, in which case an SHALL be 4'b1111.
REQ-017 In SCAN, bcd_out SHALL equal the display-register nibble selected by digit_idx; there is zero-cycle latency between digit_idx and bcd_out/an.
REQ-018 In IDLE, an SHALL be 4'b1111 and bcd_out SHALL be 0.
REQ-019 A load with every nibble <= 9 SHALL write value_in to the pending register, set the pend flag, and clear bad_bcd.
REQ-020 A load with any nibble > 9 SHALL be rejected: the pending and display registers are unchanged, and bad_bcd is set until the next accepted load.
REQ-021 A load while pend is already set SHALL overwrite the pending register (last write wins).
REQ-022 At a frame boundary with pend set, the pending register SHALL transfer to the display register and pend SHALL clear; the display register SHALL never change mid-frame (no tearing).
REQ-023 If a load coincides with a frame boundary, the boundary SHALL transfer the old pending value (if any) and the new value SHALL become pending for the next frame.
REQ-024 In IDLE, an accepted load SHALL move the value to the display register on the next cycle and enter SCAN with digit_idx=0 and counter=0; frame_done SHALL not pulse on that entry.
REQ-025 With blank_lz=1, leading-zero blanking SHALL apply as follows:
- digit 3 is blanked if it is 0;
- digit 2 is blanked if digits 3 and 2 are both 0;
- digit 1 is blanked if digits 3..1 are all 0;
- digit 0 is never blanked.
REQ-026 A change on blank_lz SHALL take effect combinationally; digit_idx sequencing SHALL be unaffected by blanking.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately force:
- state=IDLE, counter=0, digit_idx=0, an=4'b1111, bcd_out=0;
- frame_done=0, bad_bcd=0, pend=0;
- display and pending registers to 0.
REQ-028 Reset asserted mid-frame SHALL abort scanning and discard any pending value; after release the block SHALL remain in IDLE until an accepted load.

Verification (bench uses REFRESH_DIV=4)
REQ-029 Reset, then load value_in=16'h1234 -> one cycle later SCAN starts: an=1110, bcd_out=4; every 4 cycles the sequence steps (1101,3), (1011,2), (0111,1); frame_done pulses on the 3->0 wrap.
REQ-030 Scanning 16'h1234, load 16'h5678 at digit_idx=1 -> digits 1..3 still show 3,2,1; the first frame after the boundary shows 8,7,6,5.
REQ-031 Load 16'h12A4 -> bad_bcd=1 and the display still cycles the prior value; a subsequent load of 16'h0009 -> bad_bcd=0.
REQ-032 blank_lz=1 with display 16'h0040 -> an=1111 in slots 3 and 2, an=1101 with bcd_out=4 in slot 1, an=1110 with bcd_out=0 in slot 0.
REQ-033 Load asserted in the same cycle as the frame boundary, with a pending 16'h1111 and a new 16'h2222 -> the next frame shows 1111 and the following frame shows 2222.
REQ-034 rst_n pulsed low mid-slot while pend is set -> all outputs are at reset values immediately, and no digit is driven until a new load.

Source files
------------

// File: rtl/seg_scan_if.sv
// Display-scan port bundle: load/value/blanking controls in, digit drive and status out.
interface seg_scan_if;
  logic        load;
  logic [15:0] value_in;
  logic        blank_lz;
  logic [3:0]  bcd_out;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_done;
  logic        bad_bcd;

  modport master (output load, value_in, blank_lz,
                  input  bcd_out, an, digit_idx, frame_done, bad_bcd);
  modport slave  (input  load, value_in, blank_lz,
                  output bcd_out, an, digit_idx, frame_done, bad_bcd);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed BCD display scanner with double-buffered value and
// frame-aligned updates, so a new value never tears across a frame.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic     clk,
  input  logic     rst_n,
  seg_scan_if.slave bus
);
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  typedef enum logic {IDLE, SCAN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   pval_q, pval_d;
  logic          pend_q, pend_d;
  logic          bad_q, bad_d;

  logic          tick, boundary, load_ok;
  logic [3:0]    nib, blank;

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < 4; i++)
      if (bus.value_in[i*4 +: 4] > 4'd9) load_ok = 1'b0;
  end

  assign tick     = (state_q == SCAN) && (cnt_q == CNT_MAX);
  assign boundary = tick && (idx_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      disp_q  <= '0;
      pval_q  <= '0;
      pend_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      pval_q  <= pval_d;
      pend_q  <= pend_d;
      bad_q   <= bad_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    disp_d  = disp_q;
    pval_d  = pval_q;
    pend_d  = pend_q;
    bad_d   = bad_q;
    unique case (state_q)
      IDLE: begin
        // First accepted value goes straight to the display; nothing to tear yet.
        if (bus.load) begin
          if (load_ok) begin
            disp_d  = bus.value_in;
            bad_d   = 1'b0;
            state_d = SCAN;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      SCAN: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) idx_d = idx_q + 2'd1;
        // Transfer uses the old pending value; a coincident load queues behind it.
        if (boundary && pend_q) begin
          disp_d = pval_q;
          pend_d = 1'b0;
        end
        if (bus.load) begin
          if (load_ok) begin
            pval_d = bus.value_in;
            pend_d = 1'b1;
            bad_d  = 1'b0;
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Digit i (i>0) is blank when it and every digit above it are zero.
  always_comb begin
    blank    = 4'b0000;
    blank[3] = (disp_q[15:12] == 4'd0);
    blank[2] = blank[3] && (disp_q[11:8] == 4'd0);
    blank[1] = blank[2] && (disp_q[7:4] == 4'd0);
  end

  assign nib = disp_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    bus.an      = 4'b1111;
    bus.bcd_out = 4'd0;
    if (state_q == SCAN) begin
      bus.bcd_out = nib;
      if (!(bus.blank_lz && blank[idx_q])) bus.an = ~(4'b0001 << idx_q);
    end
  end

  assign bus.digit_idx  = idx_q;
  assign bus.frame_done = boundary;
  assign bus.bad_bcd    = bad_q;
endmodule
